// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the instruction-fetch / SLB RAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IF_BURST, SLB_ACT} state_e;
  localparam logic [1:0] IO_HI = 2'b11;
  localparam int INST_BYTES = 4;
endpackage

// File: rtl/if_assembler.sv
// if_assembler: walks a 4-byte fetch burst over the byte RAM and assembles the little-endian word
module if_assembler import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              i_rdy,
  input  logic              i_start,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_mem_din,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic              o_last,
  output logic              o_done,
  output logic [31:0]       o_inst
);
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [23:0]       r_bytes;
  logic              w_back;
  assign o_last = r_cnt == 3'(INST_BYTES);
  // While frozen, keep the in-flight byte's address on the bus so mem_din is valid on resume
  assign w_back = !i_rdy && r_cnt != 3'd0;
  assign o_mem_a = r_base + ADDR_W'(r_cnt) - ADDR_W'(w_back);
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      r_cnt   <= 3'd0;
      r_base  <= '0;
      r_bytes <= '0;
      o_done  <= 1'b0;
      o_inst  <= '0;
    end else begin
      o_done <= i_rdy && i_run && o_last;
      if (i_rdy && i_start) begin
        r_base <= i_addr;
        r_cnt  <= 3'd0;
      end else if (i_rdy && i_run) begin
        r_cnt <= o_last ? 3'd0 : r_cnt + 3'd1;
        if (r_cnt != 3'd0 && !o_last) r_bytes <= {i_mem_din, r_bytes[23:8]};
        if (o_last) o_inst <= {i_mem_din, r_bytes};
      end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte-RAM arbiter between instruction fetch bursts and SLB byte accesses
// Define IO_STALL_EN to hold IO-space writes while io_buffer_full and keep one idle cycle between them.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              slb_req,
  input  logic [ADDR_W-1:0] slb_addr,
  input  logic              slb_wr,
  input  logic [7:0]        slb_dout,
  output logic              slb_valid,
  output logic [7:0]        slb_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              io_buffer_full
);
  state_e            r_state;
  logic              r_last_slb;
  logic              w_slb_win, w_block, w_grant, w_if_start, w_if_run, w_if_last;
  logic [ADDR_W-1:0] w_if_a;
  assign w_slb_win = slb_req && (!if_req || !r_last_slb);
`ifdef IO_STALL_EN
  logic r_last_io;
  logic w_io_wr;
  assign w_io_wr = slb_wr && slb_addr[17:16] == IO_HI;
  assign w_block = w_io_wr && (io_buffer_full || r_last_io);
  always_ff @(posedge clk_in)
    if (!rst_in) r_last_io <= 1'b0;
    else if (rdy_in) r_last_io <= w_grant && w_io_wr;
`else
  logic w_unused;
  assign w_unused = io_buffer_full;
  assign w_block = 1'b0;
`endif
  assign w_grant = rst_in && rdy_in && !w_block &&
                   (r_state == SLB_ACT ? slb_req : r_state == IDLE && w_slb_win);
  assign w_if_start = r_state == IDLE && !w_slb_win && if_req && !clear;
  assign w_if_run = r_state == IF_BURST && !clear;
  assign slb_valid = w_grant;
  assign mem_wr = w_grant && slb_wr;
  assign mem_dout = w_grant ? slb_dout : '0;
  assign mem_a = w_grant ? slb_addr : r_state == IF_BURST ? w_if_a : '0;
  assign slb_din = mem_din;
  if_assembler #(.ADDR_W(ADDR_W)) u_if (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_rdy    (rdy_in),
    .i_start  (w_if_start),
    .i_run    (w_if_run),
    .i_addr   (if_addr),
    .i_mem_din(mem_din),
    .o_mem_a  (w_if_a),
    .o_last   (w_if_last),
    .o_done   (if_done),
    .o_inst   (if_inst)
  );
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      r_state    <= IDLE;
      r_last_slb <= 1'b0;
    end else if (rdy_in)
      case (r_state)
        IDLE:
          if (w_slb_win) r_state <= w_block ? IDLE : SLB_ACT;
          else if (if_req && !clear) r_state <= IF_BURST;
        SLB_ACT:
          if (!slb_req) begin
            r_state    <= IDLE;
            r_last_slb <= 1'b1;
          end
        IF_BURST:
          if (clear || w_if_last) begin
            r_state    <= IDLE;
            r_last_slb <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a golden byte-memory model
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, if_req, if_done, slb_req, slb_wr, slb_valid, mem_wr, io_buffer_full;
  logic [31:0] if_addr, if_inst, slb_addr, mem_a;
  logic [7:0]  slb_dout, slb_din, mem_dout, mem_din;
  logic [7:0]  ram  [4096];
  logic [7:0]  gold [4096];
  int          checks = 0, failures = 0, cyc = 0, st_from = -100;
  logic        rnd_rdy = 1'b0;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .slb_req(slb_req), .slb_addr(slb_addr), .slb_wr(slb_wr), .slb_dout(slb_dout),
    .slb_valid(slb_valid), .slb_din(slb_din),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full)
  );

  // Byte RAM with 1-cycle read latency; reloads the golden image while reset is held
  always @(posedge clk_in) begin
    if (!rst_in) for (int k = 0; k < 4096; k++) ram[k] <= gold[k];
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_in();
    @(posedge clk_in);
    #1;
    cyc++;
    rdy_in = !(cyc >= st_from && cyc < st_from + 3) && (!rnd_rdy || $urandom_range(0, 3) != 0);
  endtask

  function automatic logic [31:0] gword(input logic [31:0] a);
    logic [31:0] r, t;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      t = a + 32'(k);
      r[8*k +: 8] = gold[t[11:0]];
    end
    return r;
  endfunction

  task automatic reset_dut();
    rst_in = 1'b0; slb_req = 1'b0; if_req = 1'b0; clear = 1'b0;
    repeat (2) edge_in();
    rst_in = 1'b1;
  endtask

  task automatic fetch_op(input logic [31:0] a, input int lat);
    int n;
    logic done;
    n = 0; done = 1'b0;
    if_req = 1'b1; if_addr = a;
    while (!done && n < 80) begin
      @(negedge clk_in);
      if (!rdy_in) chk("stall_quiet", {slb_valid, mem_wr}, 0);
      if (lat > 0 && n == 0) chk("if_accept_a", mem_a, 0);
      if (lat > 0 && n >= 1 && n <= 4) chk("if_mem_a", {mem_wr, mem_a}, {1'b0, a + 32'(n) - 32'd1});
      if (if_done) begin
        done = 1'b1;
        if_req = 1'b0;
      end else begin
        edge_in();
        n++;
      end
    end
    chk("if_done_seen", done, 1);
    chk("if_inst", if_inst, gword(a));
    if (lat > 0) chk("if_latency", n, lat);
    edge_in();
    @(negedge clk_in);
    chk("if_done_pulse", if_done, 0);
    edge_in();
  endtask

  task automatic slb_op(input logic [31:0] a, input int len, input logic wr, input logic [31:0] d, input logic exact);
    int i, lim;
    logic pend;
    logic [7:0] pexp, b;
    logic [31:0] ba;
    i = 0; lim = 0; pend = 1'b0; pexp = '0;
    slb_req = 1'b1; slb_wr = wr;
    while (i < len && lim < 60) begin
      ba = a + 32'(i);
      b = d[8*i +: 8];
      slb_addr = ba; slb_dout = b;
      @(negedge clk_in);
      if (pend) begin
        chk("slb_din", slb_din, pexp);
        pend = 1'b0;
      end
      if (!rdy_in) chk("stall_quiet", {slb_valid, mem_wr}, 0);
      if (slb_valid) begin
        chk("slb_grant", {mem_wr, mem_a, mem_dout}, {wr, ba, b});
        if (wr) gold[ba[11:0]] = b;
        else begin
          pend = 1'b1;
          pexp = gold[ba[11:0]];
        end
        i++;
      end
      edge_in();
      lim++;
    end
    chk("slb_all_granted", i, len);
    if (exact) chk("slb_cycles", lim, len);
    slb_req = 1'b0;
    @(negedge clk_in);
    if (pend) chk("slb_din", slb_din, pexp);
    chk("slb_release", slb_valid, 0);
    edge_in();
  endtask

  initial begin
    int n, nbad;
    logic [31:0] ra;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b1; if_addr = '0; slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h200; slb_dout = 8'hAA;
    for (int k = 0; k < 4096; k++) gold[k] = 8'($urandom);
    gold[12'h100] = 8'h13; gold[12'h101] = 8'h05; gold[12'h102] = 8'h00; gold[12'h103] = 8'h00;
    repeat (2) edge_in();
    @(negedge clk_in);
    chk("rst_outputs", {slb_valid, mem_wr, mem_a, mem_dout, if_done}, 0);
    edge_in();
    rst_in = 1'b1; slb_req = 1'b0; if_req = 1'b0;
    @(negedge clk_in);
    chk("idle_outputs", {slb_valid, mem_wr, mem_a, mem_dout, if_done}, 0);
    edge_in();

    fetch_op(32'h100, 6);
    chk("t1_inst", if_inst, 32'h0000_0513);

    slb_op(32'h200, 4, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("t2_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEAD_BEEF);
    slb_op(32'h200, 4, 1'b0, 32'h0, 1'b1);

    fetch_op(32'hFFFF_FFFE, 6);

    clear = 1'b1;
    slb_op(32'h600, 3, 1'b1, $urandom, 1'b1);
    clear = 1'b0;

    // Simultaneous requests from reset: SLB first, then IF, then SLB waits for if_done
    reset_dut();
    if_req = 1'b1; if_addr = 32'h100;
    slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h400; slb_dout = 8'h11;
    @(negedge clk_in);
    chk("rr_slb_first", slb_valid, 1);
    gold[12'h400] = 8'h11;
    edge_in();
    slb_addr = 32'h401; slb_dout = 8'h22;
    @(negedge clk_in);
    chk("rr_slb_act", slb_valid, 1);
    gold[12'h401] = 8'h22;
    edge_in();
    slb_req = 1'b0;
    @(negedge clk_in);
    chk("rr_slb_release", slb_valid, 0);
    edge_in();
    slb_req = 1'b1; slb_addr = 32'h402; slb_dout = 8'h33;
    @(negedge clk_in);
    chk("rr_if_wins", slb_valid, 0);
    n = 0;
    while (!if_done && n < 20) begin
      edge_in();
      n++;
      @(negedge clk_in);
      if (!if_done) chk("rr_slb_waits", slb_valid, 0);
    end
    chk("rr_done", if_done, 1);
    chk("rr_inst", if_inst, gword(32'h100));
    chk("rr_latency", n, 6);
    if_req = 1'b0;
    #1;
    chk("rr_slb_after_done", slb_valid, 1);
    gold[12'h402] = 8'h33;
    edge_in();
    slb_req = 1'b0;
    @(negedge clk_in);
    edge_in();

    // Abort a fetch at cnt 2, then a new request is ignored while clear is still high
    if_req = 1'b1; if_addr = 32'h180;
    repeat (3) begin
      @(negedge clk_in);
      edge_in();
    end
    clear = 1'b1;
    @(negedge clk_in);
    chk("clr_at_cnt2", mem_a, 32'h182);
    edge_in();
    if_addr = 32'h300;
    @(negedge clk_in);
    chk("clr_idle", {if_done, mem_a}, 0);
    edge_in();
    clear = 1'b0;
    fetch_op(32'h300, 6);

    st_from = cyc + 3;
    fetch_op(32'h100, 0);
    chk("stall_inst", if_inst, 32'h0000_0513);
    st_from = cyc + 2;
    slb_op(32'h500, 4, 1'b1, 32'h1234_5678, 1'b0);
    chk("stall_ram", {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]}, 32'h1234_5678);
    st_from = cyc + 2;
    slb_op(32'h500, 4, 1'b0, 32'h0, 1'b0);
    st_from = -100;

`ifdef IO_STALL_EN
    io_buffer_full = 1'b1;
    slb_req = 1'b1; slb_wr = 1'b1; slb_addr = 32'h3_0000; slb_dout = 8'h5A;
    repeat (4) begin
      @(negedge clk_in);
      chk("io_block", {slb_valid, mem_wr}, 0);
      edge_in();
    end
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_grant", {slb_valid, mem_wr}, 2'b11);
    gold[12'h000] = 8'h5A;
    edge_in();
    slb_addr = 32'h3_0001; slb_dout = 8'hA5;
    @(negedge clk_in);
    chk("io_gap", slb_valid, 0);
    edge_in();
    @(negedge clk_in);
    chk("io_second", slb_valid, 1);
    gold[12'h001] = 8'hA5;
    edge_in();
    slb_req = 1'b0;
    @(negedge clk_in);
    edge_in();
`else
    io_buffer_full = 1'b1;
    slb_op(32'h3_0000, 2, 1'b1, 32'h0000_A55A, 1'b1);
    io_buffer_full = 1'b0;
`endif

    rnd_rdy = 1'b1;
    repeat (40) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) fetch_op(ra, 0);
      else slb_op(ra, $urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end
    rnd_rdy = 1'b0;
    repeat (2) edge_in();

    nbad = 0;
    for (int k = 0; k < 4096; k++) if (ram[k] !== gold[k]) nbad++;
    chk("ram_image", nbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
